// File: rtl/bfly_pair_feeder.sv
// Frame buffer that collects N samples and then issues the N/2 radix-2
// butterfly operand pairs (x[k], x[k+N/2]) on a valid/ready interface.
module bfly_pair_feeder #(
    parameter int WIDTH = 15,
    parameter int N     = 8,
    parameter int LOGN  = 3,
    localparam int IW   = (LOGN > 1) ? (LOGN - 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ai,
    output logic [WIDTH-1:0] bi,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [IW-1:0]    pair_idx,
    output logic             pair_last
);

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LOGN-1:0]   wr_cnt_q, wr_cnt_d;
    logic [IW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [WIDTH-1:0]  mem_q [N];
    logic              wr_en_s;
    logic              last_s;
    logic [LOGN-1:0]   lo_idx_s;
    logic [LOGN-1:0]   hi_idx_s;

    // Operand addresses: lower half at rd_cnt, upper half offset by N/2.
    assign lo_idx_s = LOGN'(rd_cnt_q);
    assign hi_idx_s = lo_idx_s + LOGN'(N / 2);
    assign last_s   = (rd_cnt_q == IW'(N / 2 - 1));

    // Next-state and counter logic for the fill/issue sequencer.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_en_s  = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    wr_en_s = 1'b1;
                    if (wr_cnt_q == LOGN'(N - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = ISSUE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + LOGN'(1);
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ISSUE: begin
                if (pair_ready) begin
                    if (last_s) begin
                        rd_cnt_d = '0;
                        state_d  = FILL;
                    end else begin
                        rd_cnt_d = rd_cnt_q + IW'(1);
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            default: begin
                state_d  = FILL;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
            end
        endcase
    end

    // Sequencer state and counters; reset wins over any concurrent transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Sample storage; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_q[wr_cnt_q] <= in_data;
        end
    end

    // Interface outputs depend only on registered state; zero outside ISSUE.
    always_comb begin
        in_ready   = (state_q == FILL);
        pair_valid = (state_q == ISSUE);
        ai         = '0;
        bi         = '0;
        pair_idx   = '0;
        pair_last  = 1'b0;
        if (state_q == ISSUE) begin
            ai        = mem_q[lo_idx_s];
            bi        = mem_q[hi_idx_s];
            pair_idx  = rd_cnt_q;
            pair_last = last_s;
        end else begin
            pair_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_bfly_pair_feeder.sv
// Self-checking bench for bfly_pair_feeder: vector table, directed corner
// sequences and random traffic against a frame-level pairing model.
module tb_bfly_pair_feeder;

    localparam int W  = 15;
    localparam int N  = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  ai;
    logic [W-1:0]  bi;
    logic          pair_valid;
    logic          pair_ready;
    logic [IW-1:0] pair_idx;
    logic          pair_last;

    bfly_pair_feeder #(.WIDTH(W), .N(N), .LOGN(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ai(ai), .bi(bi), .pair_valid(pair_valid),
        .pair_ready(pair_ready), .pair_idx(pair_idx), .pair_last(pair_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           idx;
        logic         last;
    } pair_t;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         pr;
        logic         e_ir;
        logic         e_pv;
        logic [W-1:0] e_ai;
        logic [W-1:0] e_bi;
        int           e_idx;
        logic         e_last;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] fbuf[$];
    pair_t        expq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        fbuf.delete();
        expq.delete();
    endtask

    // One cycle: apply inputs, compare against the model, advance model and clock.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic pr);
        bit    issuing;
        pair_t p;
        in_valid   = v;
        in_data    = d;
        pair_ready = pr;
        issuing    = (expq.size() != 0);
        check("exclusive", 32'(in_ready & pair_valid), 32'd0);
        check("in_ready", 32'(in_ready), 32'(!issuing));
        check("pair_valid", 32'(pair_valid), 32'(issuing));
        if (issuing) begin
            p = expq[0];
            check("ai", 32'(ai), 32'(p.a));
            check("bi", 32'(bi), 32'(p.b));
            check("pair_idx", 32'(pair_idx), 32'(p.idx));
            check("pair_last", 32'(pair_last), 32'(p.last));
            if (pr) void'(expq.pop_front());
        end else begin
            check("idle_outputs", {ai, bi, pair_idx, pair_last}, 32'd0);
            if (v) begin
                fbuf.push_back(d);
                if (fbuf.size() == N) begin
                    for (int k = 0; k < N / 2; k++) begin
                        p.a    = fbuf[k];
                        p.b    = fbuf[k + N / 2];
                        p.idx  = k;
                        p.last = (k == N / 2 - 1);
                        expq.push_back(p);
                    end
                    fbuf.delete();
                end
            end
        end
        tick();
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 15'h0123;
        pair_ready = 1'b1;
        repeat (cycles) tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    vec_t         tbl[24];
    logic [W-1:0] ext[8];
    logic [W-1:0] ext_a[4];
    logic [W-1:0] ext_b[4];

    initial begin
        int cnt;
        int cyc;
        int nxt;
        int t0, t8, t16;
        int low_cnt;
        bit acc;

        // Signed extremes: -16384, 16383, -1, 0, 1, -2, 16383, -16384.
        ext[0] = 15'h4000; ext[1] = 15'h3FFF; ext[2] = 15'h7FFF; ext[3] = 15'h0000;
        ext[4] = 15'h0001; ext[5] = 15'h7FFE; ext[6] = 15'h3FFF; ext[7] = 15'h4000;
        ext_a[0] = 15'h4000; ext_b[0] = 15'h0001;
        ext_a[1] = 15'h3FFF; ext_b[1] = 15'h7FFE;
        ext_a[2] = 15'h7FFF; ext_b[2] = 15'h3FFF;
        ext_a[3] = 15'h0000; ext_b[3] = 15'h4000;

        for (int i = 0; i < 8; i++) begin
            tbl[i]      = '{1'b1, W'(i + 1), 1'b1, 1'b1, 1'b0, '0, '0, 0, 1'b0};
            tbl[12 + i] = '{1'b1, ext[i],    1'b1, 1'b1, 1'b0, '0, '0, 0, 1'b0};
        end
        for (int k = 0; k < 4; k++) begin
            tbl[8 + k]  = '{1'b0, '0, 1'b1, 1'b0, 1'b1, W'(k + 1), W'(k + 5), k, (k == 3)};
            tbl[20 + k] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, ext_a[k], ext_b[k], k, (k == 3)};
        end

        rst = 1'b1; in_valid = 1'b0; in_data = '0; pair_ready = 1'b0;

        // Reset with in_valid high: nothing captured.
        do_reset(2);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pair_valid", 32'(pair_valid), 32'd0);
        check("rst_outputs", {ai, bi, pair_idx, pair_last}, 32'd0);

        // Vector table: basic frame 1..8 then signed extremes.
        for (int i = 0; i < 24; i++) begin
            check("tbl_in_ready", 32'(in_ready), 32'(tbl[i].e_ir));
            check("tbl_pair_valid", 32'(pair_valid), 32'(tbl[i].e_pv));
            check("tbl_ai", 32'(ai), 32'(tbl[i].e_ai));
            check("tbl_bi", 32'(bi), 32'(tbl[i].e_bi));
            check("tbl_idx", 32'(pair_idx), 32'(tbl[i].e_idx));
            check("tbl_last", 32'(pair_last), 32'(tbl[i].e_last));
            drive(tbl[i].v, tbl[i].d, tbl[i].pr);
        end

        // Backpressure: stall 3 cycles at k = 1.
        for (int i = 0; i < 8; i++) drive(1'b1, W'(i + 1), 1'b1);
        cnt = 0;
        begin
            logic prs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 7; i++) begin
                if (pair_valid && pair_idx == 2'd1 && ai == 15'd2 && bi == 15'd6) cnt++;
                drive(1'b0, '0, prs[i]);
            end
        end
        check("bp_hold_cycles", 32'(cnt), 32'd4);
        check("bp_drained", 32'(pair_valid), 32'd0);

        // Continuous streaming of 0..23 with in_valid held high.
        nxt = 0; cyc = 0; low_cnt = 0; t0 = -1; t8 = -1; t16 = -1;
        while ((nxt < 24 || expq.size() != 0) && cyc < 200) begin
            acc = (expq.size() == 0) && (nxt < 24);
            if (!in_ready) low_cnt++;
            if (acc && nxt == 0)  t0 = cyc;
            if (acc && nxt == 8)  t8 = cyc;
            if (acc && nxt == 16) t16 = cyc;
            drive(1'b1, W'(nxt), 1'b1);
            if (acc) nxt++;
            cyc++;
        end
        check("stream_timeout", 32'(cyc < 200), 32'd1);
        check("stream_ready_low", 32'(low_cnt), 32'd12);
        check("stream_period1", 32'(t8 - t0), 32'd12);
        check("stream_period2", 32'(t16 - t8), 32'd12);

        // Reset in the middle of ISSUE at k = 2.
        for (int i = 0; i < 8; i++) drive(1'b1, W'(50 + i), 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("mid_at_k2", 32'(pair_idx), 32'd2);
        do_reset(1);
        check("mid_rst_pair_valid", 32'(pair_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_outputs", {ai, bi, pair_idx, pair_last}, 32'd0);
        for (int i = 0; i < 8; i++) drive(1'b1, W'(100 + i), 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1);
        check("mid_drained", 32'(expq.size()), 32'd0);

        // Random traffic with gaps and backpressure.
        nxt = 0; cyc = 0;
        while ((nxt < 48 || expq.size() != 0) && cyc < 3000) begin
            acc = (expq.size() == 0) && (nxt < 48);
            begin
                logic v = (nxt < 48) && ($urandom_range(0, 3) != 0);
                drive(v, W'($urandom), logic'($urandom_range(0, 2) != 0));
                if (acc && v) nxt++;
            end
            cyc++;
        end
        check("rand_timeout", 32'(cyc < 3000), 32'd1);
        check("rand_drained", 32'(pair_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bfly_pair_feeder.md
Name: bfly_pair_feeder

Overview:
- Streaming input stage that sits directly upstream of the radix-2 butterfly (butterfly3r) in the transform datapath.
- Accepts one 15-bit signed sample per handshake and buffers a frame of N samples.
- Then issues N/2 butterfly operand pairs (x[k], x[k+N/2]) for k = 0..N/2-1 on a valid/ready interface.
- Its ai/bi outputs connect directly to the butterfly's ai/bi inputs.

Parameters:
- WIDTH, 15, sample width in bits (two's complement); matches the butterfly operand width.
- N, 8, frame length in samples; power of two, N >= 2.
- LOGN, 3, log2(N); the user must set it consistently with N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  signed input sample.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- ai  output  WIDTH  butterfly operand a = x[k].
- bi  output  WIDTH  butterfly operand b = x[k+N/2].
- pair_valid  output  1  ai/bi/pair_idx/pair_last are valid.
- pair_ready  input  1  downstream consumes the pair this cycle.
- pair_idx  output  max(LOGN-1,1)  k of the current pair.
- pair_last  output  1  current pair is k = N/2-1.

Behaviour:
- Storage: register array mem[0..N-1] of WIDTH bits, plus a write counter wr_cnt (LOGN bits) and a read counter rd_cnt (LOGN-1 bits, minimum 1).
- Handshake rules: a sample transfers when in_valid && in_ready on a clock edge. A pair transfers when pair_valid && pair_ready on a clock edge.
- State machine: two states, FILL and ISSUE.
- FILL:
  - in_ready = 1 and pair_valid = 0.
  - On each input transfer: mem[wr_cnt] <= in_data and wr_cnt increments.
  - On the transfer with wr_cnt = N-1: wr_cnt wraps to 0 and the state goes to ISSUE.
  - in_valid low simply holds state. Input gaps are allowed.
- ISSUE:
  - in_ready = 0 and pair_valid = 1.
  - ai = mem[rd_cnt], bi = mem[rd_cnt + N/2], pair_idx = rd_cnt, pair_last = (rd_cnt == N/2-1). All four are combinational from the registers.
  - On a pair transfer, rd_cnt increments.
  - On the pair transfer with pair_last = 1: rd_cnt wraps to 0 and the state goes to FILL.
- Outputs outside ISSUE: ai, bi, pair_idx and pair_last are driven to 0 whenever the block is not in ISSUE.
- Latency: the first pair_valid is asserted in the cycle after the edge that accepted sample N-1.
- Frame throughput: minimum period is N + N/2 cycles (N fill cycles plus N/2 issue cycles).
- Backpressure: while pair_valid && !pair_ready, ai, bi, pair_idx and pair_last hold stable. No pair is skipped or repeated.
- Input ignored in ISSUE: in_valid during ISSUE is not accepted and does not modify mem. The upstream holds the sample until in_ready returns.
- No simultaneous in/out transfer: in_ready and pair_valid are never both 1. The next frame's first sample can be accepted in the cycle after the last pair transfers.
- Arithmetic: none. Samples pass bit-exact, with no sign extension, truncation or reordering other than the pairing described above.
- Reset (rst = 1 at an edge):
  - State becomes FILL and wr_cnt = rd_cnt = 0.
  - Any partial frame or in-flight pairs are discarded.
  - mem contents are don't-care.
- Output values after reset:
  - pair_valid = 0, in_ready = 1.
  - ai = bi = 0, pair_idx = 0, pair_last = 0.
- Reset has priority over all concurrent transfers in that cycle.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid = 1 -> in_ready = 1, pair_valid = 0, ai = bi = 0. No sample is captured; the first sample after rst deassertion is stored as x[0].
- Basic frame (N = 8):
  - Stimulus: send 1..8 back-to-back, with pair_ready held at 1.
  - pairs (1,5), (2,6), (3,7), (4,8) appear on 4 consecutive cycles.
  - pair_idx = 0,1,2,3, and pair_last = 1 only on (4,8).
  - First pair_valid appears 1 cycle after sample 8 is accepted.
- Backpressure: same frame with pair_ready = 0 for 3 cycles at pair k = 1 -> (2,6) and pair_idx = 1 hold for 4 cycles; the sequence then continues with no loss or duplication.
- Continuous streaming: in_valid held at 1 with values 0..23 and pair_ready = 1.
  - Frame 0 (0..7) yields (0,4), (1,5), (2,6), (3,7).
  - Frame 1 (8..15) yields (8,12), (9,13), (10,14), (11,15).
  - Frame 2 (16..23) yields (16,20), (17,21), (18,22), (19,23).
  - in_ready is low during exactly 4 cycles per frame, giving a 12-cycle frame period.
- Reset mid-operation: pulse rst during ISSUE at k = 2 -> pair_valid = 0 next cycle. A fresh frame 100..107 then yields (100,104) .. (103,107).
- Signed extremes: frame of -16384, 16383, -1, 0, 1, -2, 16383, -16384 -> pairs (-16384,1), (16383,-2), (-1,16383), (0,-16384), bit-exact.
